contador_sched: RTL and testbench

Readout scheduler for the pop-counter bank (`contadores`). On a start pulse it waits until the FIFO subsystem is idle. It then walks the enabled counter indices in ascending order, issuing one `req`/`idx` read per counter and capturing the returned `data` on `valid`. Each result is re-emitted as a tagged one-cycle record. It sits between the system control logic and the counter bank, so that the counter bank's single read port has one sequencer.

---
 rtl/contador_pkg.sv | 21 ++
 rtl/contador_sched_if.sv | 33 +++
 rtl/contador_sched_nxt.sv | 32 +++
 rtl/contador_sched.sv | 168 ++++++++++++++++
 tb/tb_contador_sched.sv | 343 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/contador_pkg.sv
// contador_pkg: definitions shared by the readout scheduler, the counter bank
// (contadores) and their benches.
//   - NumCntDefault / DataWDefault / IdxWDefault: default bank geometry.
//   - TimeoutDefault: default wait limit for the optional scheduler timeout.
//   - sched_state_e: 3-bit scheduler FSM encoding.
package contador_pkg;

  localparam int unsigned NumCntDefault  = 5;
  localparam int unsigned DataWDefault   = 5;
  localparam int unsigned IdxWDefault    = 3;
  localparam int unsigned TimeoutDefault = 8;

  typedef enum logic [2:0] {
    StIdle      = 3'd0,
    StWaitIdle  = 3'd1,
    StIssue     = 3'd2,
    StWaitValid = 3'd3,
    StDone      = 3'd4
  } sched_state_e;

endpackage

// File: rtl/contador_sched_if.sv
// contador_sched_if: read bus between the scheduler, the counter bank and the
// result consumer.
//   cnt_req/cnt_idx   scheduler -> bank read strobe and index
//   cnt_data/cnt_valid bank -> scheduler returned value
//   rd_valid/rd_idx/rd_data/rd_err  scheduler -> consumer tagged result
// Modports: master = scheduler side, slave = bank/consumer side.
interface contador_sched_if
  import contador_pkg::*;
#(
  parameter int unsigned DATA_W = DataWDefault,
  parameter int unsigned IDX_W  = IdxWDefault
) ();

  logic              cnt_req;
  logic [IDX_W-1:0]  cnt_idx;
  logic [DATA_W-1:0] cnt_data;
  logic              cnt_valid;
  logic              rd_valid;
  logic [IDX_W-1:0]  rd_idx;
  logic [DATA_W-1:0] rd_data;
  logic              rd_err;

  modport master (
    output cnt_req, cnt_idx, rd_valid, rd_idx, rd_data, rd_err,
    input  cnt_data, cnt_valid
  );

  modport slave (
    input  cnt_req, cnt_idx, rd_valid, rd_idx, rd_data, rd_err,
    output cnt_data, cnt_valid
  );

endinterface

// File: rtl/contador_sched_nxt.sv
// contador_sched_nxt: combinational next-set-bit finder.
//   mask       candidate counter bits
//   cur        current index; only bits strictly above it qualify
//   from_start ignore cur and return the lowest set bit
//   nxt_idx    selected index (0 when nothing found)
//   found      a qualifying bit exists
module contador_sched_nxt
  import contador_pkg::*;
#(
  parameter int unsigned NUM_CNT = NumCntDefault,
  parameter int unsigned IDX_W   = IdxWDefault
) (
  input  logic [NUM_CNT-1:0] mask,
  input  logic [IDX_W-1:0]   cur,
  input  logic               from_start,
  output logic [IDX_W-1:0]   nxt_idx,
  output logic               found
);

  // Scan downwards so the last hit written is the lowest qualifying index.
  always_comb begin
    nxt_idx = '0;
    found   = 1'b0;
    for (int i = NUM_CNT - 1; i >= 0; i--) begin
      if (mask[i] && (from_start || (IDX_W'(i) > cur))) begin
        nxt_idx = IDX_W'(i);
        found   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/contador_sched.sv
// contador_sched: readout scheduler for the pop-counter bank. A start pulse
// latches en_mask, waits for fifo_idle, then reads every enabled counter in
// ascending order through the bank's single read port and re-emits each value
// as a one-cycle tagged record.
//   CLK, reset    clock and synchronous active-high reset
//   start         sweep request (ignored unless idle)
//   en_mask       counters to read, sampled with start
//   fifo_idle     FIFO subsystem quiescent
//   bus           contador_sched_if.master: cnt_* to the bank, rd_* results
//   busy, done    sweep in progress / one-cycle end-of-sweep pulse
// Build option: CONTADOR_SCHED_TIMEOUT_EN adds a TIMEOUT-cycle limit on the
// bank response; an expired wait yields rd_valid with rd_err=1, rd_data=0.
module contador_sched
  import contador_pkg::*;
#(
  parameter int unsigned NUM_CNT = NumCntDefault,
  parameter int unsigned DATA_W  = DataWDefault,
  parameter int unsigned IDX_W   = IdxWDefault,
  parameter int unsigned TIMEOUT = TimeoutDefault
) (
  input  logic                CLK,
  input  logic                reset,
  input  logic                start,
  input  logic [NUM_CNT-1:0]  en_mask,
  input  logic                fifo_idle,
  contador_sched_if.master    bus,
  output logic                busy,
  output logic                done
);

  sched_state_e       state_q, state_d;
  logic [NUM_CNT-1:0] mask_q, mask_d;
  logic [IDX_W-1:0]   cur_q, cur_d;
  logic [IDX_W-1:0]   rd_idx_q, rd_idx_d;
  logic [DATA_W-1:0]  rd_data_q, rd_data_d;
  logic               rd_valid_q, rd_valid_d;
  logic               cnt_req_q, busy_q, done_q;
  logic [NUM_CNT-1:0] srch_mask;
  logic               from_start, found, timeout;
  logic [IDX_W-1:0]   nxt_idx;

  // In idle the finder looks at the incoming mask for the lowest bit; otherwise
  // it walks the latched mask above the current index.
  assign from_start = (state_q == StIdle);
  assign srch_mask  = from_start ? en_mask : mask_q;

  contador_sched_nxt #(
    .NUM_CNT (NUM_CNT),
    .IDX_W   (IDX_W)
  ) u_nxt (
    .mask       (srch_mask),
    .cur        (cur_q),
    .from_start (from_start),
    .nxt_idx    (nxt_idx),
    .found      (found)
  );

  always_comb begin
    state_d    = state_q;
    mask_d     = mask_q;
    cur_d      = cur_q;
    rd_valid_d = 1'b0;
    rd_idx_d   = rd_idx_q;
    rd_data_d  = rd_data_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          mask_d = en_mask;
          if (!found) begin
            state_d = StDone;
          end else begin
            cur_d   = nxt_idx;
            state_d = fifo_idle ? StIssue : StWaitIdle;
          end
        end
      end
      StWaitIdle: if (fifo_idle) state_d = StIssue;
      StIssue:    state_d = StWaitValid;
      StWaitValid: begin
        if (bus.cnt_valid || timeout) begin
          rd_valid_d = 1'b1;
          rd_idx_d   = cur_q;
          rd_data_d  = bus.cnt_valid ? bus.cnt_data : '0;
          // Masked indices are skipped in the same cycle the result lands.
          if (found) begin
            cur_d   = nxt_idx;
            state_d = StIssue;
          end else begin
            state_d = StDone;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Strobes are registered from the next state so they line up with it.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q    <= StIdle;
      mask_q     <= '0;
      cur_q      <= '0;
      rd_valid_q <= 1'b0;
      rd_idx_q   <= '0;
      rd_data_q  <= '0;
      cnt_req_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mask_q     <= mask_d;
      cur_q      <= cur_d;
      rd_valid_q <= rd_valid_d;
      rd_idx_q   <= rd_idx_d;
      rd_data_q  <= rd_data_d;
      cnt_req_q  <= (state_d == StIssue);
      busy_q     <= (state_d != StIdle);
      done_q     <= (state_d == StDone);
    end
  end

`ifdef CONTADOR_SCHED_TIMEOUT_EN
  localparam int unsigned WaitW = $clog2(TIMEOUT + 1);

  logic [WaitW-1:0] wait_q, wait_d;
  logic             rd_err_q;

  // wait_q is 0 during ISSUE and counts cycles since then, so a silent bank
  // produces its error record TIMEOUT cycles after the read strobe.
  always_comb begin
    wait_d = wait_q;
    if (state_d == StIssue) begin
      wait_d = '0;
    end else if ((state_q == StIssue) || (state_q == StWaitValid)) begin
      wait_d = wait_q + WaitW'(1);
    end
  end

  // A real response in the expiry cycle wins over the timeout.
  assign timeout = (state_q == StWaitValid) && !bus.cnt_valid &&
                   ((wait_q + WaitW'(1)) == WaitW'(TIMEOUT));

  always_ff @(posedge CLK) begin
    if (reset) begin
      wait_q   <= '0;
      rd_err_q <= 1'b0;
    end else begin
      wait_q   <= wait_d;
      rd_err_q <= timeout;
    end
  end

  assign bus.rd_err = rd_err_q;
`else
  assign timeout    = 1'b0;
  assign bus.rd_err = 1'b0;
`endif

  assign bus.cnt_req  = cnt_req_q;
  assign bus.cnt_idx  = cur_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_idx   = rd_idx_q;
  assign bus.rd_data  = rd_data_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_contador_sched.sv
// tb_contador_sched: randomized self-checking bench for contador_sched. A
// behavioural bank answers reads after a programmable latency; each sweep is
// predicted from a cycle-cost schedule (lat+1 cycles per enabled counter,
// TIMEOUT cycles for a silent one) and compared with the observed events.
module tb_contador_sched;

  localparam int NC = 5;
  localparam int DW = 5;
  localparam int IW = 3;
  localparam int TO = 8;

  logic          CLK = 1'b0;
  logic          reset;
  logic          start;
  logic [NC-1:0] en_mask;
  logic          fifo_idle;
  logic          busy;
  logic          done;

  contador_sched_if #(.DATA_W(DW), .IDX_W(IW)) bus ();

  contador_sched #(
    .NUM_CNT (NC),
    .DATA_W  (DW),
    .IDX_W   (IW),
    .TIMEOUT (TO)
  ) dut (
    .CLK       (CLK),
    .reset     (reset),
    .start     (start),
    .en_mask   (en_mask),
    .fifo_idle (fifo_idle),
    .bus       (bus),
    .busy      (busy),
    .done      (done)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  int            bank_lat   = 1;
  int            silent_idx = -1;
  logic [DW-1:0] bank_val [NC];

  int rv_c[$], rv_i[$], rv_d[$], rv_e[$];
  int rq_c[$], rq_i[$];
  int dn_q[$];
  int busy_cnt;

  initial forever begin
    @(posedge CLK);
    cyc = cyc + 1;
  end

  // Bank: answers one outstanding read after bank_lat cycles, never for
  // silent_idx; drives junk data otherwise and stray valids while idle.
  initial begin
    bit pend;
    int due;
    int pidx;
    pend = 1'b0;
    due  = 0;
    pidx = 0;
    bus.cnt_valid = 1'b0;
    bus.cnt_data  = '0;
    forever begin
      @(posedge CLK);
      #1;
      bus.cnt_valid = 1'b0;
      bus.cnt_data  = DW'($urandom);
      if (pend && cyc == due) begin
        bus.cnt_valid = 1'b1;
        bus.cnt_data  = bank_val[pidx];
        pend = 1'b0;
      end else if (busy === 1'b0 && $urandom_range(0, 3) == 0) begin
        bus.cnt_valid = 1'b1;
      end
      if (bus.cnt_req === 1'b1 && int'(bus.cnt_idx) != silent_idx) begin
        pend = 1'b1;
        due  = cyc + bank_lat;
        pidx = int'(bus.cnt_idx) % NC;
      end
    end
  end

  initial forever begin
    @(negedge CLK);
    if (bus.rd_valid === 1'b1) begin
      rv_c.push_back(cyc);
      rv_i.push_back(int'(bus.rd_idx));
      rv_d.push_back(int'(bus.rd_data));
      rv_e.push_back(int'(bus.rd_err));
    end
    if (bus.cnt_req === 1'b1) begin
      rq_c.push_back(cyc);
      rq_i.push_back(int'(bus.cnt_idx));
    end
    if (done === 1'b1) dn_q.push_back(cyc);
    if (busy === 1'b1) busy_cnt++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_mon();
    rv_c.delete(); rv_i.delete(); rv_d.delete(); rv_e.delete();
    rq_c.delete(); rq_i.delete(); dn_q.delete();
    busy_cnt = 0;
  endtask

  task automatic run_sweep(input string name, input logic [NC-1:0] mask, input int lat,
                           input int idle_dly, input int silent, input bit mid_start,
                           input bit rand_vals);
    int t0, t, exp_done, budget, exp_d, n;
    int e_idx[$], e_req[$], e_rv[$];
    bank_lat   = lat;
    silent_idx = silent;
    if (rand_vals) foreach (bank_val[i]) bank_val[i] = DW'($urandom);
    clear_mon();
    t0 = cyc;
    t  = t0 + 1 + idle_dly;
    for (int i = 0; i < NC; i++) begin
      if (mask[i]) begin
        e_idx.push_back(i);
        e_req.push_back(t);
        t += (i == silent) ? TO : lat + 1;
        e_rv.push_back(t);
      end
    end
    exp_done = (e_idx.size() == 0) ? t0 + 1 : t;

    en_mask   = mask;
    start     = 1'b1;
    fifo_idle = (idle_dly == 0);
    tick();
    start   = 1'b0;
    en_mask = NC'($urandom);
    budget  = 0;
    while (dn_q.size() == 0 && budget < 200) begin
      fifo_idle = (cyc - t0 >= idle_dly);
      start     = mid_start && (cyc - t0 == 3 || cyc - t0 == idle_dly + 2);
      if (start) en_mask = ~mask;
      tick();
      budget++;
    end
    start     = 1'b0;
    fifo_idle = 1'b1;
    repeat (2) tick();

    checks++;
    if (rq_c.size() != e_req.size()) begin
      errors++;
      $display("FAIL %s req_count: got %0d, expected %0d", name, rq_c.size(), e_req.size());
    end
    n = (rq_c.size() < e_req.size()) ? rq_c.size() : e_req.size();
    for (int k = 0; k < n; k++) begin
      checks++;
      if (rq_c[k] != e_req[k] || rq_i[k] != e_idx[k]) begin
        errors++;
        $display("FAIL %s req[%0d]: got idx %0d at rel %0d, expected idx %0d at rel %0d",
                 name, k, rq_i[k], rq_c[k] - t0, e_idx[k], e_req[k] - t0);
      end
    end
    checks++;
    if (rv_c.size() != e_rv.size()) begin
      errors++;
      $display("FAIL %s rd_count: got %0d, expected %0d", name, rv_c.size(), e_rv.size());
    end
    n = (rv_c.size() < e_rv.size()) ? rv_c.size() : e_rv.size();
    for (int k = 0; k < n; k++) begin
      exp_d = (e_idx[k] == silent) ? 0 : int'(bank_val[e_idx[k]]);
      checks++;
      if (rv_c[k] != e_rv[k] || rv_i[k] != e_idx[k] || rv_d[k] != exp_d ||
          rv_e[k] != int'(e_idx[k] == silent)) begin
        errors++;
        $display("FAIL %s rd[%0d]: got rel %0d idx %0d data %0d err %0d, expected rel %0d idx %0d data %0d err %0d",
                 name, k, rv_c[k] - t0, rv_i[k], rv_d[k], rv_e[k], e_rv[k] - t0, e_idx[k],
                 exp_d, int'(e_idx[k] == silent));
      end
    end
    checks++;
    if (dn_q.size() != 1 || dn_q[0] != exp_done) begin
      errors++;
      $display("FAIL %s done: got %0d pulses first at rel %0d, expected 1 at rel %0d", name,
               dn_q.size(), (dn_q.size() > 0) ? dn_q[0] - t0 : -1, exp_done - t0);
    end
    checks++;
    if (busy_cnt != exp_done - t0) begin
      errors++;
      $display("FAIL %s busy_cycles: got %0d, expected %0d", name, busy_cnt, exp_done - t0);
    end
    if (e_idx.size() > 0) begin
      exp_d = (e_idx[$] == silent) ? 0 : int'(bank_val[e_idx[$]]);
      checks++;
      if (int'(bus.rd_idx) != e_idx[$] || int'(bus.rd_data) != exp_d) begin
        errors++;
        $display("FAIL %s rd_hold: got idx %0d data %0d, expected idx %0d data %0d", name,
                 int'(bus.rd_idx), int'(bus.rd_data), e_idx[$], exp_d);
      end
    end
  endtask

  task automatic test_reset();
    logic [15:0] outs;
    reset     = 1'b1;
    start     = 1'b0;
    en_mask   = '0;
    fifo_idle = 1'b1;
    repeat (3) tick();
    outs = {bus.cnt_req, bus.cnt_idx, bus.rd_valid, bus.rd_idx, bus.rd_data, bus.rd_err,
            busy, done};
    checks++;
    if (outs !== 16'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h, expected 0000", outs);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_full_sweep();
    bank_val = '{5'd3, 5'd7, 5'd0, 5'd31, 5'd12};
    run_sweep("full_sweep", 5'b11111, 1, 0, -1, 1'b0, 1'b0);
  endtask

  task automatic test_sparse();
    run_sweep("sparse", 5'b10010, 1, 0, -1, 1'b0, 1'b1);
  endtask

  task automatic test_empty();
    run_sweep("empty", 5'b00000, 1, 0, -1, 1'b0, 1'b1);
  endtask

  task automatic test_fifo_wait();
    run_sweep("fifo_wait", 5'b11111, 1, 4, -1, 1'b1, 1'b1);
  endtask

  task automatic test_reset_mid();
    int t0;
    logic [15:0] outs;
    bank_lat   = 1;
    silent_idx = -1;
    foreach (bank_val[i]) bank_val[i] = DW'($urandom);
    clear_mon();
    t0        = cyc;
    en_mask   = 5'b11111;
    start     = 1'b1;
    fifo_idle = 1'b1;
    tick();
    start = 1'b0;
    while (cyc < t0 + 6) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    outs = {bus.cnt_req, bus.cnt_idx, bus.rd_valid, bus.rd_idx, bus.rd_data, bus.rd_err,
            busy, done};
    checks++;
    if (outs !== 16'd0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got %h, expected 0000", outs);
    end
    repeat (4) tick();
    checks++;
    if (dn_q.size() != 0 || rv_c.size() != 2) begin
      errors++;
      $display("FAIL reset_mid_abort: got %0d done and %0d results, expected 0 and 2",
               dn_q.size(), rv_c.size());
    end
    run_sweep("after_reset", 5'b11111, 1, 0, -1, 1'b0, 1'b1);
  endtask

  task automatic test_random();
    for (int k = 0; k < 10; k++) begin
      run_sweep("random", NC'($urandom), int'($urandom_range(1, 3)),
                int'($urandom_range(0, 3)), -1, 1'b0, 1'b1);
    end
  endtask

`ifdef CONTADOR_SCHED_TIMEOUT_EN
  task automatic test_timeout();
    run_sweep("timeout", 5'b11111, 1, 0, 3, 1'b0, 1'b1);
    run_sweep("timeout_lat2", 5'b11010, 2, 1, 3, 1'b0, 1'b1);
  endtask
`else
  task automatic test_stall();
    bank_lat   = 1;
    silent_idx = 3;
    clear_mon();
    en_mask   = 5'b11111;
    start     = 1'b1;
    fifo_idle = 1'b1;
    tick();
    start = 1'b0;
    repeat (40) tick();
    checks++;
    if (rq_i.size() != 4 || rv_c.size() != 3 || dn_q.size() != 0) begin
      errors++;
      $display("FAIL stall_events: got %0d reqs %0d results %0d done, expected 4 3 0",
               rq_i.size(), rv_c.size(), dn_q.size());
    end
    checks++;
    if (busy !== 1'b1 || bus.cnt_idx !== 3'd3 || bus.cnt_req !== 1'b0) begin
      errors++;
      $display("FAIL stall_hold: got busy %b idx %0d req %b, expected 1 3 0", busy,
               bus.cnt_idx, bus.cnt_req);
    end
    reset = 1'b1;
    tick();
    reset      = 1'b0;
    silent_idx = -1;
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_full_sweep();
    test_sparse();
    test_empty();
    test_fifo_wait();
    test_reset_mid();
    test_random();
`ifdef CONTADOR_SCHED_TIMEOUT_EN
    test_timeout();
`else
    test_stall();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
